// File: rtl/evento_arbiter_pkg.sv
// rtl/evento_arbiter_pkg.sv - shared source indices, FSM states and helpers for evento_arbiter
//
// Purpose : common definitions imported by evento_arbiter and evento_picker.
//   SRC_*    : bit positions of the debounced inputs in src_level.
//   state_e  : 2-bit arbiter FSM encoding (ST_INIT, ST_IDLE, ST_OFFER, ST_BUSY).
//   wrap_next: index + 1, wrapping back to 0 at n.
package evento_arbiter_pkg;

  localparam int SRC_TEST     = 0;
  localparam int SRC_ENERGIA  = 1;
  localparam int SRC_MEDICINA = 2;
  localparam int SRC_ULT      = 3;
  localparam int SRC_FOT      = 4;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_OFFER = 2'd2,
    ST_BUSY  = 2'd3
  } state_e;

  function automatic int wrap_next(int idx, int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/evento_picker.sv
// rtl/evento_picker.sv - combinational pending-source selector (round-robin or fixed priority)
//
// Purpose : choose one pending source.
//   pending_i : pending flags, one per source
//   ptr_i     : round-robin start index (ignored when rr_mode_i=0)
//   rr_mode_i : 1 = first pending at/after ptr_i with wrap, 0 = lowest pending index
//   onehot_o  : selected source, one-hot (all zero when nothing pending)
//   id_o      : selected source index
//   any_o     : at least one source pending
module evento_picker
  import evento_arbiter_pkg::*;
#(
  parameter int N_SRC = 5,
  parameter int ID_W  = 3
) (
  input  logic [N_SRC-1:0] pending_i,
  input  logic [ID_W-1:0]  ptr_i,
  input  logic             rr_mode_i,
  output logic [N_SRC-1:0] onehot_o,
  output logic [ID_W-1:0]  id_o,
  output logic             any_o
);

  assign any_o = |pending_i;

  always_comb begin
    int          idx;
    logic [ID_W-1:0] idx_s;
    logic        found;
    onehot_o = '0;
    id_o     = '0;
    found    = 1'b0;
    idx      = 0;
    idx_s    = '0;
    // Walk the sources in search order; in RR mode the order is rotated so
    // it starts at the pointer, otherwise it starts at index 0.
    for (int k = 0; k < N_SRC; k++) begin
      idx = rr_mode_i ? (int'(ptr_i) + k) : k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      idx_s = ID_W'(idx);
      if (!found && pending_i[idx_s]) begin
        found           = 1'b1;
        onehot_o[idx_s] = 1'b1;
        id_o            = idx_s;
      end
    end
  end

endmodule

// File: rtl/evento_arbiter.sv
// rtl/evento_arbiter.sv - debounced-level to one-shot event arbiter with valid/ready/done handshake
//
// Purpose : converts rising edges of debounced levels into pending events, offers
//   them one at a time to the mode FSM, and waits for completion before the next.
// Ports:
//   clk, reset_tmp      : clock, asynchronous active-high reset
//   src_level[N_SRC]    : debounced levels (test, energia, medicina, ult, fot)
//   ev_valid/ev_id/ev_onehot : offered event; ev_onehot is zero when ev_valid=0
//   ev_ready            : consumer accepts the offered event
//   ev_done             : consumer finished the accepted event (ignored outside BUSY)
//   busy                : high while waiting for ev_done
//   err_timeout         : 1-cycle pulse when the BUSY wait expires
//   drop_flags/clr_drop : sticky lost-event flags and their clear
//   ev_count            : per-source accept counters, CNT_W bits each
// Build option: EVENT_COUNT_EN enables saturating per-source counters; otherwise
//   ev_count is tied to zero.
module evento_arbiter
  import evento_arbiter_pkg::*;
#(
  parameter int N_SRC       = 5,
  parameter int ID_W        = 3,
  parameter int ARB_RR      = 1,
  parameter int TIMEOUT_CYC = 50000000,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset_tmp,
  input  logic [N_SRC-1:0]       src_level,
  output logic                   ev_valid,
  output logic [ID_W-1:0]        ev_id,
  output logic [N_SRC-1:0]       ev_onehot,
  input  logic                   ev_ready,
  input  logic                   ev_done,
  output logic                   busy,
  output logic                   err_timeout,
  output logic [N_SRC-1:0]       drop_flags,
  input  logic                   clr_drop,
  output logic [N_SRC*CNT_W-1:0] ev_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   prev_q;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   drop_q, drop_d;
  logic [N_SRC-1:0]   onehot_q, onehot_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               err_q, err_d;

  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   clr_pend;
  logic               accept;
  logic [N_SRC-1:0]   pick_onehot;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;

  // INIT only captures the levels, so anything already high at reset release
  // is treated as the baseline rather than as an edge.
  assign rise     = (state_q == ST_INIT) ? '0 : (src_level & ~prev_q);
  assign accept   = (state_q == ST_OFFER) && ev_ready;
  assign clr_pend = accept ? onehot_q : '0;

  // A rise in the same cycle the flag is consumed re-arms it and is not a loss.
  assign pending_d = (pending_q & ~clr_pend) | rise;
  // New drops are OR-ed after the clear so a simultaneous drop survives clr_drop.
  assign drop_d    = (drop_q & ~{N_SRC{clr_drop}}) | (rise & pending_q & ~clr_pend);

  evento_picker #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_picker (
    .pending_i (pending_q),
    .ptr_i     (rr_q),
    .rr_mode_i (ARB_RR != 0),
    .onehot_o  (pick_onehot),
    .id_o      (pick_id),
    .any_o     (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    onehot_d = onehot_q;
    rr_d     = rr_q;
    tmr_d    = '0;
    err_d    = 1'b0;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (pick_any) begin
          id_d     = pick_id;
          onehot_d = pick_onehot;
          state_d  = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (ev_ready) begin
          rr_d    = ID_W'(wrap_next(int'(id_q), N_SRC));
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (ev_done) begin
          state_d = ST_IDLE;
        end else if (tmr_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset_tmp) begin
    if (reset_tmp) begin
      state_q   <= ST_INIT;
      prev_q    <= '0;
      pending_q <= '0;
      drop_q    <= '0;
      onehot_q  <= '0;
      id_q      <= '0;
      rr_q      <= '0;
      tmr_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= src_level;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      onehot_q  <= onehot_d;
      id_q      <= id_d;
      rr_q      <= rr_d;
      tmr_q     <= tmr_d;
      err_q     <= err_d;
    end
  end

  assign ev_valid    = (state_q == ST_OFFER);
  assign ev_id       = id_q;
  assign ev_onehot   = ev_valid ? onehot_q : '0;
  assign busy        = (state_q == ST_BUSY);
  assign err_timeout = err_q;
  assign drop_flags  = drop_q;

`ifdef EVENT_COUNT_EN
  logic [CNT_W-1:0] cnt_q [N_SRC];

  always_ff @(posedge clk or posedge reset_tmp) begin
    if (reset_tmp) begin
      for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (onehot_q[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_cnt
    assign ev_count[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`else
  assign ev_count = '0;
`endif

endmodule

// File: tb/tb_evento_arbiter.sv
// tb/tb_evento_arbiter.sv - self-checking bench for evento_arbiter (fixed-priority and round-robin)
module tb_evento_arbiter;

  localparam int N   = 5;
  localparam int IDW = 3;
  localparam int TO  = 20;
  localparam int CW  = 2;
  localparam int PH_INIT = 0, PH_IDLE = 1, PH_OFFER = 2, PH_BUSY = 3;
`ifdef EVENT_COUNT_EN
  localparam int EXP_CNT1 = 3;
`else
  localparam int EXP_CNT1 = 0;
`endif

  logic clk = 1'b0;
  logic reset_tmp = 1'b1;
  logic [N-1:0] src_level = '0;
  logic ev_ready = 1'b0, ev_done = 1'b0, clr_drop = 1'b0;

  logic            valid_w [2];
  logic [IDW-1:0]  id_w    [2];
  logic [N-1:0]    oh_w    [2];
  logic            busy_w  [2];
  logic            err_w   [2];
  logic [N-1:0]    drop_w  [2];
  logic [N*CW-1:0] cnt_w   [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Instance 0: fixed priority, instance 1: round-robin. Both see the same inputs.
  evento_arbiter #(.N_SRC(N), .ID_W(IDW), .ARB_RR(0), .TIMEOUT_CYC(TO), .CNT_W(CW)) u_fp (
    .clk(clk), .reset_tmp(reset_tmp), .src_level(src_level),
    .ev_valid(valid_w[0]), .ev_id(id_w[0]), .ev_onehot(oh_w[0]),
    .ev_ready(ev_ready), .ev_done(ev_done), .busy(busy_w[0]), .err_timeout(err_w[0]),
    .drop_flags(drop_w[0]), .clr_drop(clr_drop), .ev_count(cnt_w[0]));

  evento_arbiter #(.N_SRC(N), .ID_W(IDW), .ARB_RR(1), .TIMEOUT_CYC(TO), .CNT_W(CW)) u_rr (
    .clk(clk), .reset_tmp(reset_tmp), .src_level(src_level),
    .ev_valid(valid_w[1]), .ev_id(id_w[1]), .ev_onehot(oh_w[1]),
    .ev_ready(ev_ready), .ev_done(ev_done), .busy(busy_w[1]), .err_timeout(err_w[1]),
    .drop_flags(drop_w[1]), .clr_drop(clr_drop), .ev_count(cnt_w[1]));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int          m_phase [2];
  logic [N-1:0] m_pend [2];
  logic [N-1:0] m_drop [2];
  logic [N-1:0] m_prev [2];
  int          m_id    [2];
  int          m_ptr   [2];
  int          m_wait  [2];
  logic        m_err   [2];
  int          m_cnt   [2][N];

  function automatic int pick(logic [N-1:0] p, int ptr, bit rr);
    for (int k = 0; k < N; k++) begin
      int j = rr ? (ptr + k) % N : k;
      if (p[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_phase[m] = PH_INIT; m_pend[m] = '0; m_drop[m] = '0; m_prev[m] = '0;
      m_id[m] = 0; m_ptr[m] = 0; m_wait[m] = 0; m_err[m] = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[m][i] = 0;
    end
  endtask

  task automatic model_step(int m);
    logic [N-1:0] old_pend;
    old_pend = m_pend[m];
    if (clr_drop) m_drop[m] = '0;
    if (m_phase[m] == PH_OFFER && ev_ready) m_pend[m][m_id[m]] = 1'b0;
    if (m_phase[m] != PH_INIT) begin
      for (int i = 0; i < N; i++) begin
        if (src_level[i] && !m_prev[m][i]) begin
          if (m_pend[m][i]) m_drop[m][i] = 1'b1;
          m_pend[m][i] = 1'b1;
        end
      end
    end
    m_prev[m] = src_level;
    m_err[m] = 1'b0;
    case (m_phase[m])
      PH_INIT: m_phase[m] = PH_IDLE;
      PH_IDLE: if (old_pend != 0) begin
        m_id[m] = pick(old_pend, m_ptr[m], m == 1);
        m_phase[m] = PH_OFFER;
      end
      PH_OFFER: if (ev_ready) begin
        m_ptr[m] = (m_id[m] + 1) % N;
        if (m_cnt[m][m_id[m]] < (1 << CW) - 1) m_cnt[m][m_id[m]]++;
        m_wait[m] = 0;
        m_phase[m] = PH_BUSY;
      end
      default: begin
        if (ev_done) m_phase[m] = PH_IDLE;
        else if (m_wait[m] == TO - 1) begin m_err[m] = 1'b1; m_phase[m] = PH_IDLE; end
        else m_wait[m]++;
      end
    endcase
  endtask

  always @(posedge clk or posedge reset_tmp) begin
    if (reset_tmp) model_reset();
    else for (int m = 0; m < 2; m++) model_step(m);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [N-1:0]    eoh;
    logic [N*CW-1:0] ecnt;
    for (int m = 0; m < 2; m++) begin
      eoh = '0;
      if (m_phase[m] == PH_OFFER) eoh[m_id[m]] = 1'b1;
      ecnt = '0;
`ifdef EVENT_COUNT_EN
      for (int i = 0; i < N; i++) ecnt[i*CW +: CW] = CW'(m_cnt[m][i]);
`endif
      check($sformatf("ev_valid[%0d]", m), valid_w[m], m_phase[m] == PH_OFFER);
      if (m_phase[m] == PH_OFFER) check($sformatf("ev_id[%0d]", m), id_w[m], m_id[m]);
      check($sformatf("ev_onehot[%0d]", m), oh_w[m], eoh);
      check($sformatf("busy[%0d]", m), busy_w[m], m_phase[m] == PH_BUSY);
      check($sformatf("err_timeout[%0d]", m), err_w[m], m_err[m]);
      check($sformatf("drop_flags[%0d]", m), drop_w[m], m_drop[m]);
      check($sformatf("ev_count[%0d]", m), cnt_w[m], ecnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (valid_w[0] && valid_w[1]) begin ok = 1'b1; break; end
      tick();
    end
    check("wait_valid", ok, 1);
  endtask

  task automatic serve();
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    ev_done  = 1'b1; tick(); ev_done  = 1'b0;
  endtask

  initial begin
    int n;
    model_reset();
    src_level = 5'b00100;
    repeat (3) tick();
    for (int m = 0; m < 2; m++) begin
      check("reset ev_valid", valid_w[m], 0);
      check("reset ev_id", id_w[m], 0);
      check("reset ev_onehot", oh_w[m], 0);
      check("reset busy", busy_w[m], 0);
      check("reset err", err_w[m], 0);
      check("reset drop", drop_w[m], 0);
      check("reset count", cnt_w[m], 0);
    end
    reset_tmp = 1'b0;

    // 1: level high through release is not an event; fall+rise is, 2 cycles later
    repeat (6) tick();
    check("t1 no event on held level", valid_w[1], 0);
    src_level[2] = 1'b0; tick();
    src_level[2] = 1'b1; tick();
    check("t1 valid one cycle after rise", valid_w[0], 0);
    tick();
    check("t1 valid two cycles after rise", valid_w[0], 1);
    check("t1 id fp", id_w[0], 2);
    check("t1 id rr", id_w[1], 2);
    serve();

    // move the RR pointer to 1 by serving source 0
    src_level[0] = 1'b1; tick();
    wait_valid();
    check("ptr setup id", id_w[1], 0);
    serve();
    src_level[0] = 1'b0; tick();

    // 2: simultaneous rises on 0 and 3
    src_level[0] = 1'b1; src_level[3] = 1'b1; tick();
    wait_valid();
    check("t2 fp first", id_w[0], 0);
    check("t2 rr first", id_w[1], 3);
    check("t2 fp onehot", oh_w[0], 5'b00001);
    serve();
    wait_valid();
    check("t2 fp second", id_w[0], 3);
    check("t2 rr second", id_w[1], 0);
    serve();
    src_level = '0; tick();

    // 3: two rises on source 1 before accept
    src_level[1] = 1'b1; tick();
    src_level[1] = 1'b0; tick();
    src_level[1] = 1'b1; tick();
    check("t3 drop fp", drop_w[0], 5'b00010);
    check("t3 drop rr", drop_w[1], 5'b00010);
    wait_valid();
    check("t3 id", id_w[0], 1);
    serve();
    repeat (4) tick();
    check("t3 single event", valid_w[0], 0);
    clr_drop = 1'b1; tick(); clr_drop = 1'b0;
    check("t3 clr_drop", drop_w[0], 0);
    src_level[1] = 1'b0; tick();

    // 4: accept source 4 and never finish
    src_level[4] = 1'b1; tick();
    wait_valid();
    check("t4 id", id_w[1], 4);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    n = 0;
    while (!err_w[1] && n < 40) begin tick(); n++; end
    check("t4 timeout cycles", n, 20);
    check("t4 err fp", err_w[0], 1);
    check("t4 back to idle", busy_w[1], 0);
    tick();
    check("t4 err pulse width", err_w[1], 0);
    src_level[4] = 1'b0; tick();

    // 5: reset while offering
    src_level[3] = 1'b1; tick();
    wait_valid();
    #1 reset_tmp = 1'b1;
    #1 check("t5 async valid fp", valid_w[0], 0);
    check("t5 async valid rr", valid_w[1], 0);
    check("t5 async onehot", oh_w[1], 0);
    tick(); tick();
    reset_tmp = 1'b0;
    repeat (6) tick();
    check("t5 pending discarded", valid_w[1], 0);
    src_level[3] = 1'b0; tick();

    // 6: five accepts of source 1
    for (int r = 0; r < 5; r++) begin
      src_level[1] = 1'b1; tick();
      wait_valid();
      serve();
      src_level[1] = 1'b0; tick();
    end
    check("t6 count fp", cnt_w[0][CW +: CW], EXP_CNT1);
    check("t6 count rr", cnt_w[1][CW +: CW], EXP_CNT1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) src_level[i] = ~src_level[i];
      ev_ready = ($urandom_range(1) == 1);
      ev_done  = ($urandom_range(5) == 0);
      clr_drop = ($urandom_range(15) == 0);
      reset_tmp = ($urandom_range(299) == 0);
      tick();
    end
    reset_tmp = 1'b0; ev_ready = 1'b0; ev_done = 1'b0; clr_drop = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
